// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and de-glitches the pins, frames 11-bit
// packets, and folds E0/F0 prefixes into one make/break event per scan code.
module ps2_key_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_ready,
  output logic       make,
  output logic       ext,
  output logic [7:0] key_input,
  output logic       frame_error,
  output logic [1:0] dbg_state
);

  localparam int FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FCW-1:0] FILT_MAX  = FCW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                 r_filt_clk;
  logic [FCW-1:0]       r_filt_cnt;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit_cnt;
  logic                 r_parity;
  logic [TW-1:0]        r_timer;
  logic                 r_ext_flag;
  logic                 r_brk_flag;
  logic                 w_clk_s;
  logic                 w_data_s;
  logic                 w_fall;
  logic                 w_timeout;
  logic                 w_good;
  logic                 w_bad;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_dat_sync[SYNC_STAGES-1];
  // Fall strobe fires in the same cycle the filtered level drops.
  assign w_fall   = r_filt_clk & ~w_clk_s & (r_filt_cnt == FILT_MAX);
  assign w_timeout = (r_state != IDLE) & ~w_fall & (r_timer == TIMER_MAX);
  assign dbg_state = r_state;

  // Synchronisers idle high to match the undriven PS/2 bus, so reset
  // release never manufactures a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      if (w_clk_s != r_filt_clk) begin
        if (r_filt_cnt == FILT_MAX) begin
          r_filt_clk <= w_clk_s;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_bad       = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        IDLE:   if (!w_data_s) w_state_nxt = DATA;
        DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        PARITY: w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          w_good      = w_data_s & (^r_shift ^ r_parity);
          w_bad       = ~w_good;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_timer   <= '0;
    end else begin
      if (r_state == IDLE || w_fall) r_timer <= '0;
      else                           r_timer <= r_timer + 1'b1;
      if (w_fall) begin
        case (r_state)
          IDLE:   r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {w_data_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          PARITY: r_parity <= w_data_s;
          default: ;
        endcase
      end
    end
  end

  // Event generation: outputs update the cycle after the stop-bit fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_ready   <= 1'b0;
      frame_error <= 1'b0;
      make        <= 1'b0;
      ext         <= 1'b0;
      key_input   <= '0;
      r_ext_flag  <= 1'b0;
      r_brk_flag  <= 1'b0;
    end else begin
      key_ready   <= 1'b0;
      frame_error <= 1'b0;
      if (w_bad) begin
        frame_error <= 1'b1;
        r_ext_flag  <= 1'b0;
        r_brk_flag  <= 1'b0;
      end else if (w_good) begin
        case (r_shift)
          8'hE0: r_ext_flag <= 1'b1;
          8'hF0: r_brk_flag <= 1'b1;
          8'hE1: ;
          default: begin
            key_ready  <= 1'b1;
            key_input  <= r_shift;
            make       <= ~r_brk_flag;
            ext        <= r_ext_flag;
            r_ext_flag <= 1'b0;
            r_brk_flag <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: bit-banged PS/2 frames in, expected
// events queued per frame and matched against key_ready/frame_error pulses.
module tb_ps2_key_decoder;

  localparam int TIMEOUT = 1000;
  localparam int HALF    = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready;
  logic       make;
  logic       ext;
  logic [7:0] key_input;
  logic       frame_error;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  last_key = 8'h00;
  localparam logic [10:0] ERR_EV = 11'h400;

  ps2_key_decoder #(
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT), .FILTER_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_ready(key_ready), .make(make), .ext(ext), .key_input(key_input),
    .frame_error(frame_error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] key_ev(input logic mk, input logic ex, input logic [7:0] code);
    return {1'b0, mk, ex, code};
  endfunction

  // One PS/2 bit: data set while clock high, then a low and a high phase,
  // optionally with a single-cycle glitch in each phase.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(posedge clk);
    if (glitch) begin
      ps2_clk = 1'b1; @(posedge clk); ps2_clk = 1'b0;
    end
    repeat (HALF - 8) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (8) @(posedge clk);
    if (glitch) begin
      ps2_clk = 1'b0; @(posedge clk); ps2_clk = 1'b1;
    end
    repeat (HALF - 8) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop, input bit glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(~(^b) ^ bad_par, glitch);
    ps2_bit(stop, glitch);
    ps2_data = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits - 1; i++) ps2_bit(b[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic send_key(input logic [7:0] code, input logic mk, input logic ex);
    exp_q.push_back(key_ev(mk, ex, code));
    if (ex)  send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    if (!mk) send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(code, 1'b0, 1'b1, 1'b0);
  endtask

  // Scoreboard side: every output pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (reset && (key_ready || frame_error)) begin
      logic [10:0] got;
      logic [10:0] exp;
      check_eq("exclusive", {31'd0, key_ready & frame_error}, 32'd0);
      got = frame_error ? ERR_EV : {1'b0, make, ext, key_input};
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", {21'd0, got}, 32'hFFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        check_eq("event", {21'd0, got}, {21'd0, exp});
        if (frame_error) check_eq("key_hold", {24'd0, key_input}, {24'd0, last_key});
        else             last_key = exp[7:0];
      end
    end
  end

  task automatic drain(input string tag);
    repeat (200) @(posedge clk);
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, key_ready}, 0);
    check_eq("rst_err", {31'd0, frame_error}, 0);
    check_eq("rst_key", {24'd0, key_input}, 0);
    check_eq("rst_mkext", {30'd0, make, ext}, 0);
    check_eq("rst_state", {30'd0, dbg_state}, 0);
    reset = 1'b1;
    repeat (20) @(posedge clk);

    send_key(8'h1C, 1'b1, 1'b0);
    drain("q_make_1c");
    send_key(8'h1C, 1'b0, 1'b0);
    drain("q_break_1c");
    send_key(8'h75, 1'b1, 1'b1);
    send_key(8'h75, 1'b0, 1'b1);
    send_key(8'h75, 1'b1, 1'b0);
    drain("q_ext_seq");

    // E0 E0 still yields a single extended event; E1 is swallowed.
    exp_q.push_back(key_ev(1'b1, 1'b1, 8'h6B));
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(key_ev(1'b1, 1'b0, 8'h29));
    send_frame(8'hE1, 1'b0, 1'b1, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    drain("q_e0e0_e1");

    exp_q.push_back(ERR_EV);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    drain("q_parity_err");
    exp_q.push_back(ERR_EV);
    exp_q.push_back(key_ev(1'b1, 1'b0, 8'h1C));
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    drain("q_stop_err");

    exp_q.push_back(ERR_EV);
    send_partial(8'h29, 5);
    repeat (TIMEOUT + 10) @(posedge clk);
    exp_q.push_back(key_ev(1'b1, 1'b0, 8'h29));
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    drain("q_timeout");

    send_partial(8'h55, 4);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_rst_state", {30'd0, dbg_state}, 0);
    check_eq("mid_rst_key", {24'd0, key_input}, 0);
    reset = 1'b1;
    last_key = 8'h00;
    repeat (10) @(posedge clk);
    exp_q.push_back(key_ev(1'b1, 1'b0, 8'h1C));
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    drain("q_rst_glitch");

    for (int i = 0; i < 4; i++) begin
      logic [7:0] code;
      code = 8'($urandom_range(8'h01, 8'h7F));
      send_key(code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain("q_random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
